// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the read and write pointer domains.
// Holds the default depth and the pointer address-width derivation.
package fifo_pkg;

   localparam int unsigned FIFO_DEPTH_DEF = 50;

   // The address must also hold the value FIFO_DEPTH so that a full level can be reported.
   function automatic int unsigned addr_width(int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mod_ptr.sv
// Mod-DEPTH address counter with a wrap bit, shared by the read and write sides.
// Output is {wrap, addr}; the wrap bit toggles each time the address rolls over.
module fifo_mod_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned AW    = addr_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_i,
   output logic [AW:0]   ptr_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic          wrap_q, wrap_d;
   logic          last;

   assign last = (addr_q == AW'(DEPTH - 1));

   always_comb begin
      addr_d = addr_q;
      wrap_d = wrap_q;
      if (inc_i) begin
         if (last) begin
            addr_d = '0;
            wrap_d = ~wrap_q;
         end else begin
            addr_d = addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wrap_q <= wrap_d;
      end
   end

   assign ptr_o = {wrap_q, addr_q};

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: write pointer, full/level/almost-full
// flags against the synchronised read pointer, and a sticky overflow flag.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
   localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clkw_i,
   input  logic                  rst_i,
   input  logic                  wren_i,
   input  logic [ADDR_WIDTH:0]   rd_ptr_i,
   input  logic                  ovf_clr_i,
   output logic [ADDR_WIDTH:0]   wr_ptr_o,
   output logic [ADDR_WIDTH-1:0] wr_ptr_buff_o,
   output logic                  buff_we_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH-1:0] level_o,
   output logic                  overflow_o
);

   localparam logic [ADDR_WIDTH-1:0] DepthW = ADDR_WIDTH'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] AfW    = ADDR_WIDTH'(AF_THRESH);

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wrap_eq;
   logic                  overflow_q, overflow_d;

   fifo_mod_ptr #(
      .DEPTH (FIFO_DEPTH),
      .AW    (ADDR_WIDTH)
   ) u_wr_ptr (
      .clk_i (clkw_i),
      .rst_i (rst_i),
      .inc_i (buff_we_o),
      .ptr_o (wr_ptr)
   );

   assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign rd_addr = rd_ptr_i[ADDR_WIDTH-1:0];
   assign wrap_eq = (wr_ptr[ADDR_WIDTH] == rd_ptr_i[ADDR_WIDTH]);

   always_comb begin
      full_o = ~wrap_eq && (wr_addr == rd_addr);
      // Addresses count mod FIFO_DEPTH, so a crossed wrap adds FIFO_DEPTH back.
      if (wrap_eq) begin
         level_o = wr_addr - rd_addr;
      end else begin
         level_o = DepthW - rd_addr + wr_addr;
      end
      almost_full_o = (level_o >= AfW);
      buff_we_o     = wren_i & ~full_o;
   end

   // Set takes priority over clear.
   always_comb begin
      overflow_d = overflow_q;
      if (ovf_clr_i) begin
         overflow_d = 1'b0;
      end
      if (wren_i && full_o) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clkw_i) begin
      if (rst_i) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign wr_ptr_o      = wr_ptr;
   assign wr_ptr_buff_o = wr_ptr[ADDR_WIDTH-1:0];
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed and scoreboard-checked bench for fifo_wr_ctrl at the default depth of 50.
module tb_fifo_wr_ctrl;

   localparam int D = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic       wren;
   logic [6:0] rd_ptr;
   logic       ovf_clr;
   logic [6:0] wr_ptr;
   logic [5:0] wr_buff;
   logic       buff_we;
   logic       full;
   logic       afull;
   logic [5:0] level;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   fifo_wr_ctrl dut (
      .clkw_i        (clk),
      .rst_i         (rst),
      .wren_i        (wren),
      .rd_ptr_i      (rd_ptr),
      .ovf_clr_i     (ovf_clr),
      .wr_ptr_o      (wr_ptr),
      .wr_ptr_buff_o (wr_buff),
      .buff_we_o     (buff_we),
      .full_o        (full),
      .almost_full_o (afull),
      .level_o       (level),
      .overflow_o    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ptr_next(input logic [6:0] p);
      if (p[5:0] == 6'(D - 1)) return {~p[6], 6'd0};
      return p + 7'd1;
   endfunction

   initial begin
      logic [6:0] m_wr, m_rd;
      int cnt, k, mx;

      rst = 1'b1; wren = 1'b0; rd_ptr = '0; ovf_clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check_eq("rst_wr_ptr", wr_ptr, 0);
      check_eq("rst_wr_buff", wr_buff, 0);
      check_eq("rst_full", full, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_afull", afull, 0);
      check_eq("rst_ovf", ovf, 0);
      check_eq("rst_we_idle", buff_we, 0);
      wren = 1'b1;
      #1;
      check_eq("rst_we_wren", buff_we, 1);

      // Fill to full; almost_full from level 48.
      for (int i = 0; i < D; i++) begin
         check_eq("fill_level", level, i);
         check_eq("fill_afull", afull, (i >= 48) ? 1 : 0);
         step();
      end
      check_eq("fill_wr_ptr", wr_ptr, 7'h40);
      check_eq("fill_full", full, 1);
      check_eq("fill_level50", level, D);
      check_eq("fill_afull50", afull, 1);

      // Overflow set, clear, and set-wins-over-clear.
      check_eq("ovf_we_blocked", buff_we, 0);
      check_eq("ovf_pre", ovf, 0);
      step();
      wren = 1'b0;
      check_eq("ovf_ptr_hold", wr_ptr, 7'h40);
      check_eq("ovf_set", ovf, 1);
      ovf_clr = 1'b1;
      step();
      check_eq("ovf_clr", ovf, 0);
      wren = 1'b1;
      step();
      check_eq("ovf_set_wins", ovf, 1);
      check_eq("ovf_ptr_hold2", wr_ptr, 7'h40);
      wren = 1'b0;
      step();
      ovf_clr = 1'b0;
      check_eq("ovf_clr2", ovf, 0);

      // Wrap: reader catches up to {1,0}, then 50 more writes.
      rd_ptr = 7'h40;
      #1;
      check_eq("wrap_empty_lvl", level, 0);
      check_eq("wrap_empty_full", full, 0);
      wren = 1'b1;
      repeat (D) step();
      wren = 1'b0;
      #1;
      check_eq("wrap_wr_ptr", wr_ptr, 0);
      check_eq("wrap_full", full, 1);
      check_eq("wrap_level", level, D);

      // Cross-wrap level: wr {1,5}, rd {0,45}.
      rd_ptr = 7'h00;
      wren = 1'b1;
      repeat (45) step();
      rd_ptr = 7'd45;
      repeat (10) step();
      wren = 1'b0;
      #1;
      check_eq("xw_wr_ptr", wr_ptr, 7'h45);
      check_eq("xw_level", level, 10);
      check_eq("xw_full", full, 0);
      rd_ptr = 7'h45;
      #1;
      check_eq("xw_level0", level, 0);
      check_eq("xw_full0", full, 0);

      // Reset mid-operation at {0,17}, with overflow set beforehand.
      rst = 1'b1;
      rd_ptr = '0;
      step();
      rst = 1'b0;
      wren = 1'b1;
      repeat (17) step();
      wren = 1'b0;
      check_eq("mid_wr_ptr17", wr_ptr, 17);
      rd_ptr = 7'h40 | 7'd17;
      wren = 1'b1;
      #1;
      check_eq("mid_full", full, 1);
      step();
      check_eq("mid_ovf_set", ovf, 1);
      rst = 1'b1;
      rd_ptr = '0;
      step();
      check_eq("mid_rst_ptr", wr_ptr, 0);
      check_eq("mid_rst_ovf", ovf, 0);
      rst = 1'b0;
      step();
      wren = 1'b0;
      check_eq("mid_resume", wr_ptr, 1);

      // Random traffic against a scoreboard count.
      rst = 1'b1;
      rd_ptr = '0;
      step();
      rst = 1'b0;
      m_wr = '0; m_rd = '0; cnt = 0;
      for (int n = 0; n < 400; n++) begin
         wren   = ($urandom_range(0, 9) < 7);
         rd_ptr = m_rd;
         #1;
         check_eq("rnd_level", level, cnt);
         check_eq("rnd_level_max", (level <= 6'(D)) ? 1 : 0, 1);
         check_eq("rnd_full", full, (cnt == D) ? 1 : 0);
         check_eq("rnd_wr_ptr", wr_ptr, m_wr);
         step();
         if (wren && cnt != D) begin
            m_wr = ptr_next(m_wr);
            cnt++;
         end
         mx = (cnt < 3) ? cnt : 3;
         k  = $urandom_range(0, mx);
         for (int j = 0; j < k; j++) m_rd = ptr_next(m_rd);
         cnt -= k;
      end
      wren = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
